plru_array: RTL and testbench
=============================

# plru_array

Parametrised tree pseudo-LRU state store for an N-way set-associative cache. One state word per set, NUM_WAYS-1 bits each. Two touch ports apply hit/fill updates internally via read-modify-write; the caller never computes next-state. A registered lookup port returns the victim way. A multi-cycle flush walks every set back to the reset state. Sits beside the tag/data arrays in the cache datapath.

## Interface
- S_INDEX, default 4: set-index width; NUM_SETS = 2**S_INDEX.
- NUM_WAYS, default 4: associativity; power of two, at least 2; WIDTH = NUM_WAYS-1, WAY_W = $clog2(NUM_WAYS).

Ports:
- clk0  in  1  clock; all state updates on its rising edge.
- rst0_n  in  1  reset, asynchronous and active-low.
- rd_en  in  1  lookup request.
- rd_set  in  S_INDEX  lookup set.
- victim_valid  out  1  victim_way/state_out valid for last accepted lookup.
- victim_way  out  WAY_W  PLRU victim of the looked-up set.
- state_out  out  WIDTH  raw tree bits of the looked-up set.
- touch_en[0..1]  in  1 each  apply touch on port p.
- touch_set[0..1]  in  S_INDEX each  set to update.
- touch_way[0..1]  in  WAY_W each  way just used (hit or fill).
- flush_req  in  1  start full-array clear.
- busy  out  1  flush in progress.

## Operation
- Tree encoding: bit i is heap node i; children of i are 2i+1 and 2i+2. The leaves, left to right, are ways 0..NUM_WAYS-1.
- Victim walk: start at the root. Bit 0 means go left; bit 1 means go right.
- Touch way w: on every node of w's path, set the bit to point away from w. The bit becomes 1 if w is in the node's left subtree and 0 if it is in the right subtree. Off-path bits are unchanged.
- Two touch ports in one cycle:
  - Different sets: both are applied independently.
  - Same set: port 0's update is applied first, then port 1's update is applied to that result. Port 1 wins on shared nodes.
- Lookup: when rd_en is high and the FSM is in IDLE, rd_set is captured into a register and victim_valid is set to 1. When rd_en is low, victim_valid becomes 0 and the address register holds.
- victim_way and state_out are decoded combinationally from the live array at the registered address. They therefore track later touches to that set.
- FSM IDLE:
  - flush_req moves to FLUSH and loads the counter with 0.
  - Touches and lookups operate normally.
- FSM FLUSH:
  - Each cycle, set[counter] is cleared to 0 and the counter increments.
  - At counter == NUM_SETS-1 the FSM returns to IDLE.
  - Touches are dropped.
  - rd_en is ignored and victim_valid is 0.
  - flush_req is ignored.
- busy = (state == FLUSH).
- Reset (asynchronous, any time, including mid-flush):
  - All sets become 0, the FSM goes to IDLE and the counter to 0.
  - victim_valid = 0, busy = 0, victim_way = 0 and state_out = 0 (address register cleared to 0).

## Timing
- Touch presented in cycle t is committed at the end of cycle t.
- Lookup latency is 1 cycle. rd_en in cycle t gives outputs valid during cycle t+1.
- A touch and a lookup to the same set in the same cycle t: the outputs in t+1 reflect the post-touch state (write-before-read transparency).
- Flush accepted in cycle t: busy is high for cycles t+1 .. t+NUM_SETS.
  - Touches and lookups are accepted again in cycle t+NUM_SETS+1.
  - A touch in cycle t itself (the flush_req cycle) is still applied and then flushed.
- There are no combinational paths from inputs to outputs.

## Structure
- Package plru_pkg holds:
  - the flush FSM state enum (IDLE, FLUSH);
  - a localparam helper for WAY_W derivation.
- Sub-module plru_tree, parametrised by NUM_WAYS, is purely combinational:
  - inputs: state and way;
  - outputs: next_state (touch applied) and victim.
- Instantiate plru_tree three times:
  - touch port 0 on array[touch_set[0]];
  - touch port 1 on the port-0 result when the sets match and port 0 is enabled, otherwise on array[touch_set[1]];
  - victim decode on array[addr_reg].
- The top level holds the array, address register, FSM and counter.

## Test plan
All scenarios use NUM_WAYS=4 and S_INDEX=4.
- Reset then lookup set 5 -> victim_valid=1, victim_way=0, state_out=3'b000.
- Touch way 0 on set 5, lookup next cycle -> state_out=3'b011, victim_way=2. Then touch way 2 -> state_out=3'b110, victim_way=1.
- Same cycle: port 0 touches way 0 and port 1 touches way 1, both on set 3 -> state_out=3'b001, victim_way=2. Touch of ways 2 and 0 on sets 7 and 9 in one cycle -> set 7 = 3'b110, set 9 = 3'b011.
- Touch way 3 on set 4 while rd_en targets set 4 in the same cycle -> next cycle state_out=3'b000 (root 0, node 2 = 0), victim_way=0.
- Dirty sets 0, 8, 15, then pulse flush_req:
  - busy is high for exactly 16 cycles;
  - touches during the flush are dropped and lookups give victim_valid=0;
  - afterwards all sets read 3'b000.
- Assert rst0_n low asynchronously at flush counter 6 -> busy drops immediately, all sets read 0, and a new flush_req is accepted after reset is released.

Source files
------------

// File: rtl/plru_pkg.sv
// Shared types and helpers for the tree pseudo-LRU state store.
package plru_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      FLUSH = 1'b1
   } flush_state_e;

   // Way-index width for a given associativity.
   function automatic int unsigned way_bits(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/plru_array_if.sv
// Lookup, touch and flush signals between the cache controller and plru_array.
interface plru_array_if
   import plru_pkg::*;
#(
   parameter int unsigned S_INDEX  = 4,
   parameter int unsigned NUM_WAYS = 4
);
   localparam int unsigned WIDTH = NUM_WAYS - 1;
   localparam int unsigned WAY_W = way_bits(NUM_WAYS);

   logic               rd_en;
   logic [S_INDEX-1:0] rd_set;
   logic               victim_valid;
   logic [WAY_W-1:0]   victim_way;
   logic [WIDTH-1:0]   state_out;
   logic [1:0]         touch_en;
   logic [S_INDEX-1:0] touch_set [2];
   logic [WAY_W-1:0]   touch_way [2];
   logic               flush_req;
   logic               busy;

   modport master (
      output rd_en, rd_set, touch_en, touch_set, touch_way, flush_req,
      input  victim_valid, victim_way, state_out, busy
   );

   modport slave (
      input  rd_en, rd_set, touch_en, touch_set, touch_way, flush_req,
      output victim_valid, victim_way, state_out, busy
   );

endinterface

// File: rtl/plru_tree.sv
// Combinational tree-PLRU: applies a touch to one state word and decodes its victim.
module plru_tree
   import plru_pkg::*;
#(
   parameter  int unsigned NUM_WAYS = 4,
   localparam int unsigned WIDTH    = NUM_WAYS - 1,
   localparam int unsigned WAY_W    = way_bits(NUM_WAYS)
) (
   input  logic [WIDTH-1:0] state,
   input  logic [WAY_W-1:0] way,
   output logic [WIDTH-1:0] next_state,
   output logic [WAY_W-1:0] victim
);

   // Heap walk: each node on the way's path is pointed away from it.
   always_comb begin
      int unsigned node;
      next_state = state;
      node       = 0;
      for (int unsigned l = 0; l < WAY_W; l++) begin
         next_state[node] = ~way[WAY_W-1-l];
         node = 2 * node + 1 + {31'b0, way[WAY_W-1-l]};
      end
   end

   always_comb begin
      int unsigned vnode;
      victim = '0;
      vnode  = 0;
      for (int unsigned l = 0; l < WAY_W; l++) begin
         victim[WAY_W-1-l] = state[vnode];
         vnode = 2 * vnode + 1 + {31'b0, state[vnode]};
      end
   end

endmodule

// File: rtl/plru_array.sv
// Per-set tree-PLRU state array with two touch ports, registered victim lookup and walking flush.
module plru_array
   import plru_pkg::*;
#(
   parameter int unsigned S_INDEX  = 4,
   parameter int unsigned NUM_WAYS = 4
) (
   input logic         clk0,
   input logic         rst0_n,
   plru_array_if.slave bus
);

   localparam int unsigned NUM_SETS = 2 ** S_INDEX;
   localparam int unsigned WIDTH    = NUM_WAYS - 1;
   localparam int unsigned WAY_W    = way_bits(NUM_WAYS);

   logic [WIDTH-1:0]   mem [NUM_SETS];
   logic [S_INDEX-1:0] addr_q;
   logic [S_INDEX-1:0] cnt_q;
   logic               vv_q;
   flush_state_e       state_q, state_d;
   logic               flushing;
   logic               chain;
   logic [WIDTH-1:0]   t0_next, t1_in, t1_next;
   logic [WIDTH-1:0]   dec_next_unused;
   logic [WAY_W-1:0]   t0_victim_unused, t1_victim_unused;

   // Same-set touches chain so port 1 sees port 0's result.
   assign chain = bus.touch_en[0] && (bus.touch_set[0] == bus.touch_set[1]);
   assign t1_in = chain ? t0_next : mem[bus.touch_set[1]];

   plru_tree #(.NUM_WAYS(NUM_WAYS)) u_touch0 (
      .state      (mem[bus.touch_set[0]]),
      .way        (bus.touch_way[0]),
      .next_state (t0_next),
      .victim     (t0_victim_unused)
   );

   plru_tree #(.NUM_WAYS(NUM_WAYS)) u_touch1 (
      .state      (t1_in),
      .way        (bus.touch_way[1]),
      .next_state (t1_next),
      .victim     (t1_victim_unused)
   );

   plru_tree #(.NUM_WAYS(NUM_WAYS)) u_decode (
      .state      (mem[addr_q]),
      .way        ('0),
      .next_state (dec_next_unused),
      .victim     (bus.victim_way)
   );

   always_ff @(posedge clk0 or negedge rst0_n) begin
      if (!rst0_n) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.flush_req) state_d = FLUSH;
         FLUSH:   if (cnt_q == '1)   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      flushing = (state_q == FLUSH);
   end

   always_ff @(posedge clk0 or negedge rst0_n) begin
      if (!rst0_n)       cnt_q <= '0;
      else if (flushing) cnt_q <= cnt_q + 1'b1;
      else               cnt_q <= '0;
   end

   for (genvar s = 0; s < NUM_SETS; s++) begin : g_set
      always_ff @(posedge clk0 or negedge rst0_n) begin
         if (!rst0_n) begin
            mem[s] <= '0;
         end else if (flushing) begin
            if (cnt_q == S_INDEX'(s)) mem[s] <= '0;
         end else if (bus.touch_en[1] && bus.touch_set[1] == S_INDEX'(s)) begin
            mem[s] <= t1_next;
         end else if (bus.touch_en[0] && bus.touch_set[0] == S_INDEX'(s)) begin
            mem[s] <= t0_next;
         end
      end
   end

   always_ff @(posedge clk0 or negedge rst0_n) begin
      if (!rst0_n) begin
         addr_q <= '0;
         vv_q   <= 1'b0;
      end else if (!flushing && bus.rd_en) begin
         addr_q <= bus.rd_set;
         vv_q   <= 1'b1;
      end else begin
         vv_q   <= 1'b0;
      end
   end

   assign bus.victim_valid = vv_q;
   assign bus.state_out    = mem[addr_q];
   assign bus.busy         = flushing;

endmodule

// File: tb/tb_plru_array.sv
// Directed self-checking bench for plru_array with 4 ways and 16 sets.
module tb_plru_array;

   logic clk0   = 1'b0;
   logic rst0_n = 1'b1;
   int   checks = 0;
   int   errors = 0;

   plru_array_if #(.S_INDEX(4), .NUM_WAYS(4)) bus ();

   plru_array #(.S_INDEX(4), .NUM_WAYS(4)) dut (
      .clk0   (clk0),
      .rst0_n (rst0_n),
      .bus    (bus)
   );

   always #5 clk0 = ~clk0;

   task automatic idle_inputs();
      bus.rd_en     = 1'b0;
      bus.rd_set    = '0;
      bus.touch_en  = '0;
      bus.flush_req = 1'b0;
      for (int p = 0; p < 2; p++) begin
         bus.touch_set[p] = '0;
         bus.touch_way[p] = '0;
      end
   endtask

   task automatic commit();
      @(posedge clk0);
      #1;
      idle_inputs();
   endtask

   task automatic touch(input int p, input logic [3:0] s, input logic [1:0] w);
      bus.touch_en[p]  = 1'b1;
      bus.touch_set[p] = s;
      bus.touch_way[p] = w;
   endtask

   task automatic lookup(input logic [3:0] s);
      bus.rd_en  = 1'b1;
      bus.rd_set = s;
      commit();
   endtask

   task automatic test_reset();
      idle_inputs();
      #3 rst0_n = 1'b0;
      #1;
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", bus.busy); end
      checks++; if (bus.victim_valid !== 1'b0) begin errors++; $display("FAIL reset_vv got %0b want 0", bus.victim_valid); end
      checks++; if (bus.victim_way !== 2'd0) begin errors++; $display("FAIL reset_way got %0d want 0", bus.victim_way); end
      checks++; if (bus.state_out !== 3'b000) begin errors++; $display("FAIL reset_state got %b want 000", bus.state_out); end
      #18 rst0_n = 1'b1;
      commit();
      lookup(4'd5);
      checks++; if (bus.victim_valid !== 1'b1) begin errors++; $display("FAIL lookup5_vv got %0b want 1", bus.victim_valid); end
      checks++; if (bus.victim_way !== 2'd0) begin errors++; $display("FAIL lookup5_way got %0d want 0", bus.victim_way); end
      checks++; if (bus.state_out !== 3'b000) begin errors++; $display("FAIL lookup5_state got %b want 000", bus.state_out); end
      commit();
      checks++; if (bus.victim_valid !== 1'b0) begin errors++; $display("FAIL vv_drop got %0b want 0", bus.victim_valid); end
   endtask

   task automatic test_touch_single();
      touch(0, 4'd5, 2'd0);
      commit();
      lookup(4'd5);
      checks++; if (bus.state_out !== 3'b011) begin errors++; $display("FAIL t0_state got %b want 011", bus.state_out); end
      checks++; if (bus.victim_way !== 2'd2) begin errors++; $display("FAIL t0_way got %0d want 2", bus.victim_way); end
      // No new lookup: outputs must follow the live set at the held address.
      touch(1, 4'd5, 2'd2);
      commit();
      checks++; if (bus.state_out !== 3'b110) begin errors++; $display("FAIL t2_track_state got %b want 110", bus.state_out); end
      checks++; if (bus.victim_way !== 2'd1) begin errors++; $display("FAIL t2_track_way got %0d want 1", bus.victim_way); end
      checks++; if (bus.victim_valid !== 1'b0) begin errors++; $display("FAIL t2_track_vv got %0b want 0", bus.victim_valid); end
   endtask

   task automatic test_dual_touch();
      touch(0, 4'd7, 2'd0);
      commit();
      touch(0, 4'd3, 2'd0);
      touch(1, 4'd3, 2'd1);
      commit();
      lookup(4'd3);
      checks++; if (bus.state_out !== 3'b001) begin errors++; $display("FAIL same_set_state got %b want 001", bus.state_out); end
      checks++; if (bus.victim_way !== 2'd2) begin errors++; $display("FAIL same_set_way got %0d want 2", bus.victim_way); end
      touch(0, 4'd10, 2'd1);
      touch(1, 4'd10, 2'd0);
      commit();
      lookup(4'd10);
      checks++; if (bus.state_out !== 3'b011) begin errors++; $display("FAIL port1_wins got %b want 011", bus.state_out); end
      touch(0, 4'd7, 2'd2);
      touch(1, 4'd9, 2'd0);
      commit();
      lookup(4'd7);
      checks++; if (bus.state_out !== 3'b110) begin errors++; $display("FAIL split_set7 got %b want 110", bus.state_out); end
      checks++; if (bus.victim_way !== 2'd1) begin errors++; $display("FAIL split_set7_way got %0d want 1", bus.victim_way); end
      lookup(4'd9);
      checks++; if (bus.state_out !== 3'b011) begin errors++; $display("FAIL split_set9 got %b want 011", bus.state_out); end
   endtask

   task automatic test_bypass();
      touch(0, 4'd4, 2'd1);
      bus.rd_en  = 1'b1;
      bus.rd_set = 4'd4;
      commit();
      checks++; if (bus.state_out !== 3'b001) begin errors++; $display("FAIL bypass1_state got %b want 001", bus.state_out); end
      checks++; if (bus.victim_way !== 2'd2) begin errors++; $display("FAIL bypass1_way got %0d want 2", bus.victim_way); end
      touch(1, 4'd4, 2'd3);
      bus.rd_en  = 1'b1;
      bus.rd_set = 4'd4;
      commit();
      checks++; if (bus.state_out !== 3'b000) begin errors++; $display("FAIL bypass2_state got %b want 000", bus.state_out); end
      checks++; if (bus.victim_way !== 2'd0) begin errors++; $display("FAIL bypass2_way got %0d want 0", bus.victim_way); end
      checks++; if (bus.victim_valid !== 1'b1) begin errors++; $display("FAIL bypass2_vv got %0b want 1", bus.victim_valid); end
   endtask

   task automatic test_flush();
      int busy_cycles;
      touch(0, 4'd0, 2'd0);
      touch(1, 4'd8, 2'd0);
      commit();
      touch(0, 4'd15, 2'd0);
      commit();
      lookup(4'd15);
      checks++; if (bus.state_out !== 3'b011) begin errors++; $display("FAIL dirty15 got %b want 011", bus.state_out); end
      bus.flush_req = 1'b1;
      touch(0, 4'd2, 2'd0);
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL busy_req_cycle got %0b want 0", bus.busy); end
      commit();
      busy_cycles = 0;
      for (int i = 0; i < 40 && bus.busy; i++) begin
         busy_cycles++;
         touch(0, 4'd0, 2'd3);
         bus.rd_en     = 1'b1;
         bus.rd_set    = 4'd8;
         bus.flush_req = 1'b1;
         commit();
         checks++; if (bus.victim_valid !== 1'b0) begin errors++; $display("FAIL flush_vv cycle %0d got %0b want 0", i, bus.victim_valid); end
      end
      checks++; if (busy_cycles != 16) begin errors++; $display("FAIL busy_len got %0d want 16", busy_cycles); end
      for (int s = 0; s < 16; s++) begin
         lookup(4'(s));
         checks++; if (bus.state_out !== 3'b000) begin errors++; $display("FAIL flushed_set%0d got %b want 000", s, bus.state_out); end
      end
      touch(0, 4'd6, 2'd0);
      commit();
      lookup(4'd6);
      checks++; if (bus.state_out !== 3'b011) begin errors++; $display("FAIL post_flush_touch got %b want 011", bus.state_out); end
   endtask

   task automatic test_reset_mid_flush();
      int busy_cycles;
      touch(0, 4'd12, 2'd0);
      commit();
      bus.flush_req = 1'b1;
      commit();
      repeat (6) commit();
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL midflush_busy got %0b want 1", bus.busy); end
      #2 rst0_n = 1'b0;
      #1;
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL async_busy got %0b want 0", bus.busy); end
      #2 rst0_n = 1'b1;
      commit();
      lookup(4'd12);
      checks++; if (bus.state_out !== 3'b000) begin errors++; $display("FAIL rst_set12 got %b want 000", bus.state_out); end
      lookup(4'd6);
      checks++; if (bus.state_out !== 3'b000) begin errors++; $display("FAIL rst_set6 got %b want 000", bus.state_out); end
      lookup(4'd3);
      checks++; if (bus.state_out !== 3'b000) begin errors++; $display("FAIL rst_set3 got %b want 000", bus.state_out); end
      bus.flush_req = 1'b1;
      commit();
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL reflush_busy got %0b want 1", bus.busy); end
      busy_cycles = 0;
      for (int i = 0; i < 40 && bus.busy; i++) begin
         busy_cycles++;
         commit();
      end
      checks++; if (busy_cycles != 16) begin errors++; $display("FAIL reflush_len got %0d want 16", busy_cycles); end
   endtask

   initial begin
      test_reset();
      test_touch_single();
      test_dual_touch();
      test_bypass();
      test_flush();
      test_reset_mid_flush();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog expired");
   end

endmodule
